// File: rtl/bg_sched_pkg.sv
// Shared types, scene codes and scene-selection helpers for the background scene scheduler.
package bg_sched_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShow   = 2'd1,
    StBlank  = 2'd2,
    StManual = 2'd3
  } state_e;

  localparam logic [1:0] SCENE_DUNES   = 2'd0;
  localparam logic [1:0] SCENE_PLANETS = 2'd1;
  localparam logic [1:0] SCENE_MARIO   = 2'd2;
  localparam logic [1:0] SCENE_NONE    = 2'd3;
  localparam int unsigned NUM_SCENES   = 3;

  function automatic logic in_mask(input logic [2:0] mask, input logic [1:0] s);
    case (s)
      SCENE_DUNES:   return mask[0];
      SCENE_PLANETS: return mask[1];
      SCENE_MARIO:   return mask[2];
      default:       return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] scene_onehot(input logic [1:0] s);
    case (s)
      SCENE_DUNES:   return 3'b001;
      SCENE_PLANETS: return 3'b010;
      SCENE_MARIO:   return 3'b100;
      default:       return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] lowest_scene(input logic [2:0] mask);
    if (mask[0])      return SCENE_DUNES;
    else if (mask[1]) return SCENE_PLANETS;
    else if (mask[2]) return SCENE_MARIO;
    else              return SCENE_NONE;
  endfunction

  // Search order (s+1)%3, (s+2)%3, then s itself so a lone scene reloads.
  function automatic logic [1:0] next_scene(input logic [1:0] s, input logic [2:0] mask);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = (s >= 2'd2) ? 2'd0 : s + 2'd1;
    c2 = (s == 2'd0) ? 2'd2 : s - 2'd1;
    if (in_mask(mask, c1))      return c1;
    else if (in_mask(mask, c2)) return c2;
    else                        return s;
  endfunction

endpackage

// File: rtl/bg_frame_tick.sv
// Registers vsync and produces a one-clock frame tick on its rising edge.
module bg_frame_tick (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vsync_i,
  output logic tick_o
);

  logic vsync_q;
  logic armed_q, armed_d;

  // Ticks stay blocked after reset until vsync has been seen low once.
  always_comb begin
    armed_d = armed_q | ~vsync_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vsync_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      vsync_q <= vsync_i;
      armed_q <= armed_d;
    end
  end

  assign tick_o = vsync_i & ~vsync_q & armed_q;

endmodule

// File: rtl/bg_scene_scheduler.sv
// Rotates background scenes on frame ticks with optional blank gaps and a manual override.
module bg_scene_scheduler
  import bg_sched_pkg::*;
#(
  parameter int unsigned HOLD_W  = 8,
  parameter int unsigned BLANK_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               manual,
  input  logic [1:0]         manual_sel,
  input  logic [2:0]         scene_mask,
  input  logic [HOLD_W-1:0]  hold_frames,
  input  logic [BLANK_W-1:0] blank_frames,
  input  logic               vsync,
  input  logic               irq_clr,
  output logic [2:0]         bg_en,
  output logic [1:0]         scene,
  output logic [HOLD_W-1:0]  frame_cnt,
  output logic [1:0]         state,
  output logic               scene_irq
);

  logic              tick;
  state_e            state_q, state_d;
  logic [1:0]        scene_q, scene_d;
  logic [2:0]        bg_en_q, bg_en_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic              irq_q, irq_d, irq_set;
  logic              hold_hit, blank_hit, step;
  logic [1:0]        nxt;

  bg_frame_tick u_frame_tick (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .vsync_i(vsync),
    .tick_o (tick)
  );

  always_comb begin
    state_d   = state_q;
    scene_d   = scene_q;
    bg_en_d   = bg_en_q;
    cnt_d     = cnt_q;
    irq_set   = 1'b0;
    cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + HOLD_W'(1);
    hold_hit  = (hold_frames != '0) && (cnt_q == hold_frames - HOLD_W'(1));
    // A zero blank count mid-BLANK would otherwise never match, so treat it as done.
    blank_hit = (blank_frames == '0) ||
                (cnt_q == HOLD_W'(blank_frames - BLANK_W'(1)));
    step      = hold_hit || !in_mask(scene_mask, scene_q);
    nxt       = next_scene(scene_q, scene_mask);

    if (tick && manual && state_q != StManual) begin
      state_d = StManual;
      scene_d = manual_sel;
      bg_en_d = scene_onehot(manual_sel);
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (tick && enable && scene_mask != 3'b000) begin
            state_d = StShow;
            scene_d = lowest_scene(scene_mask);
            bg_en_d = scene_onehot(lowest_scene(scene_mask));
            cnt_d   = '0;
          end
        end
        StShow, StBlank: begin
          if (!enable || scene_mask == 3'b000) begin
            state_d = StIdle;
            bg_en_d = 3'b000;
            cnt_d   = '0;
          end else if (tick) begin
            if ((state_q == StShow && step) || (state_q == StBlank && blank_hit)) begin
              cnt_d = '0;
              if (state_q == StShow && blank_frames != '0) begin
                state_d = StBlank;
                bg_en_d = 3'b000;
              end else begin
                state_d = StShow;
                scene_d = nxt;
                bg_en_d = scene_onehot(nxt);
                irq_set = 1'b1;
              end
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        StManual: begin
          if (tick) begin
            if (!manual) begin
              state_d = StIdle;
              bg_en_d = 3'b000;
            end else begin
              scene_d = manual_sel;
              bg_en_d = scene_onehot(manual_sel);
            end
          end
        end
        default: begin
          state_d = StIdle;
          bg_en_d = 3'b000;
          cnt_d   = '0;
        end
      endcase
    end

    irq_d = irq_set | (irq_q & ~irq_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      scene_q <= SCENE_DUNES;
      bg_en_q <= 3'b000;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      scene_q <= scene_d;
      bg_en_q <= bg_en_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
    end
  end

  assign bg_en     = bg_en_q;
  assign scene     = scene_q;
  assign frame_cnt = cnt_q;
  assign state     = state_q;
  assign scene_irq = irq_q;

endmodule

// File: tb/tb_bg_scene_scheduler.sv
// Directed table-driven bench for bg_scene_scheduler with hand-written corner sequences.
module tb_bg_scene_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       manual = 1'b0;
  logic [1:0] manual_sel = 2'd0;
  logic [2:0] scene_mask = 3'b000;
  logic [7:0] hold_frames = 8'd0;
  logic [3:0] blank_frames = 4'd0;
  logic       vsync = 1'b0;
  logic       irq_clr = 1'b0;
  logic [2:0] bg_en;
  logic [1:0] scene;
  logic [7:0] frame_cnt;
  logic [1:0] state;
  logic       scene_irq;

  int n_tests = 0;
  int n_fail = 0;
  int onehot_bad = 0;

  bg_scene_scheduler #(.HOLD_W(8), .BLANK_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .manual      (manual),
    .manual_sel  (manual_sel),
    .scene_mask  (scene_mask),
    .hold_frames (hold_frames),
    .blank_frames(blank_frames),
    .vsync       (vsync),
    .irq_clr     (irq_clr),
    .bg_en       (bg_en),
    .scene       (scene),
    .frame_cnt   (frame_cnt),
    .state       (state),
    .scene_irq   (scene_irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ($countones(bg_en) > 1) onehot_bad = 1;
  end

  typedef struct {
    logic       en;
    logic       clr;
    logic [2:0] mask;
    logic [7:0] hold;
    logic [3:0] blank;
    logic [2:0] exp_bg;
    logic [1:0] exp_scene;
    logic [1:0] exp_state;
    logic [7:0] exp_cnt;
    logic       exp_irq;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One vsync pulse: tick is seen at the first rising edge after vsync goes high.
  task automatic vtick();
    @(negedge clk) vsync = 1'b1;
    @(negedge clk) vsync = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 3'b111, 8'd2, 4'd0, 3'b001, 2'd0, 2'd1, 8'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 3'b111, 8'd2, 4'd0, 3'b001, 2'd0, 2'd1, 8'd1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 3'b111, 8'd2, 4'd0, 3'b010, 2'd1, 2'd1, 8'd0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 3'b111, 8'd2, 4'd0, 3'b010, 2'd1, 2'd1, 8'd1, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 3'b111, 8'd2, 4'd0, 3'b100, 2'd2, 2'd1, 8'd0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 3'b111, 8'd2, 4'd0, 3'b100, 2'd2, 2'd1, 8'd1, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 3'b111, 8'd2, 4'd0, 3'b001, 2'd0, 2'd1, 8'd0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 3'b111, 8'd2, 4'd0, 3'b001, 2'd0, 2'd1, 8'd1, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 3'b111, 8'd2, 4'd0, 3'b000, 2'd0, 2'd0, 8'd0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 3'b101, 8'd1, 4'd2, 3'b001, 2'd0, 2'd1, 8'd0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 3'b101, 8'd1, 4'd2, 3'b000, 2'd0, 2'd2, 8'd0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 3'b101, 8'd1, 4'd2, 3'b000, 2'd0, 2'd2, 8'd1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 3'b101, 8'd1, 4'd2, 3'b100, 2'd2, 2'd1, 8'd0, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 3'b101, 8'd1, 4'd2, 3'b000, 2'd2, 2'd2, 8'd0, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 3'b101, 8'd1, 4'd2, 3'b000, 2'd2, 2'd2, 8'd1, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 3'b101, 8'd1, 4'd2, 3'b001, 2'd0, 2'd1, 8'd0, 1'b1};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst state", 32'(state), 32'd0);
    check("rst scene", 32'(scene), 32'd0);
    check("rst bg_en", 32'(bg_en), 32'd0);
    check("rst frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst irq", 32'(scene_irq), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Rotation with and without blank gaps
    for (int i = 0; i < 16; i++) begin
      enable       = tbl[i].en;
      irq_clr      = tbl[i].clr;
      scene_mask   = tbl[i].mask;
      hold_frames  = tbl[i].hold;
      blank_frames = tbl[i].blank;
      vtick();
      irq_clr = 1'b0;
      check($sformatf("row%0d bg_en", i), 32'(bg_en), 32'(tbl[i].exp_bg));
      check($sformatf("row%0d scene", i), 32'(scene), 32'(tbl[i].exp_scene));
      check($sformatf("row%0d state", i), 32'(state), 32'(tbl[i].exp_state));
      check($sformatf("row%0d frame_cnt", i), 32'(frame_cnt), 32'(tbl[i].exp_cnt));
      check($sformatf("row%0d irq", i), 32'(scene_irq), 32'(tbl[i].exp_irq));
    end

    // Clearing the current scene's mask bit forces a step even with hold=0
    scene_mask = 3'b111; hold_frames = 8'd0; blank_frames = 4'd0;
    scene_mask = 3'b110;
    vtick();
    check("maskclr scene1", 32'(scene), 32'd1);
    scene_mask = 3'b101;
    vtick();
    check("maskclr scene2", 32'(scene), 32'd2);
    check("maskclr bg_en", 32'(bg_en), 32'b100);
    @(negedge clk) scene_mask = 3'b000;
    @(posedge clk) #1;
    check("mask0 bg_en", 32'(bg_en), 32'd0);
    check("mask0 state", 32'(state), 32'd0);

    // Manual override
    scene_mask = 3'b111;
    vtick();
    check("man pre bg_en", 32'(bg_en), 32'b001);
    @(negedge clk) begin manual = 1'b1; manual_sel = 2'd2; end
    @(negedge clk);
    check("man no tick bg_en", 32'(bg_en), 32'b001);
    vtick();
    check("man bg_en", 32'(bg_en), 32'b100);
    check("man state", 32'(state), 32'd3);
    check("man scene", 32'(scene), 32'd2);
    @(negedge clk) manual_sel = 2'd3;
    @(negedge clk);
    check("man sel hold", 32'(bg_en), 32'b100);
    vtick();
    check("man none bg_en", 32'(bg_en), 32'b000);
    manual = 1'b0;
    vtick();
    check("man exit state", 32'(state), 32'd0);

    // scene_irq set/clear collision
    @(negedge clk) irq_clr = 1'b1;
    @(negedge clk) irq_clr = 1'b0;
    check("irq cleared", 32'(scene_irq), 32'd0);
    hold_frames = 8'd1;
    vtick();
    check("irq idle entry", 32'(scene_irq), 32'd0);
    @(negedge clk) begin vsync = 1'b1; irq_clr = 1'b1; end
    @(negedge clk) begin vsync = 1'b0; irq_clr = 1'b0; end
    check("irq set wins", 32'(scene_irq), 32'd1);
    check("irq step scene", 32'(scene), 32'd1);
    @(negedge clk) irq_clr = 1'b1;
    @(negedge clk) irq_clr = 1'b0;
    check("irq clr alone", 32'(scene_irq), 32'd0);

    // frame_cnt saturation
    hold_frames = 8'd0;
    for (int i = 0; i < 260; i++) vtick();
    check("sat frame_cnt", 32'(frame_cnt), 32'hff);
    check("sat state", 32'(state), 32'd1);

    // Async reset with vsync high, then the arming requirement
    @(negedge clk) vsync = 1'b1;
    @(posedge clk) #2 rst_n = 1'b0;
    #1;
    check("async rst bg_en", 32'(bg_en), 32'd0);
    check("async rst state", 32'(state), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no early tick", 32'(state), 32'd0);
    @(negedge clk) vsync = 1'b0;
    @(negedge clk) vsync = 1'b1;
    @(negedge clk) vsync = 1'b0;
    check("first tick state", 32'(state), 32'd1);
    check("first tick bg_en", 32'(bg_en), 32'b001);

    check("onehot", 32'(onehot_bad), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
